// File: rtl/rect_issue_scheduler.sv
// rtl/rect_issue_scheduler.sv - round-robin issue scheduler sharing the rectangle-placement pipeline
// Optional feature macro: DIM_CHECK_EN (reject width/height outside 4..16 with an error response)
module rect_issue_scheduler #(
   parameter int NUM_REQ  = 4,
   parameter int SLOT_CYC = 4,
   parameter int RSP_LAT  = 8,
   parameter int ID_W     = 2,
   parameter int PH_W     = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [NUM_REQ-1:0]   req_valid_i,
   input  logic [5*NUM_REQ-1:0] req_width_i,
   input  logic [5*NUM_REQ-1:0] req_height_i,
   output logic [NUM_REQ-1:0]   req_ready_o,
   output logic [4:0]           pl_width_o,
   output logic [4:0]           pl_height_o,
   output logic                 pl_issue_o,
   output logic [PH_W-1:0]      slot_phase_o,
   input  logic [7:0]           pl_x_i,
   input  logic [7:0]           pl_y_i,
   input  logic [3:0]           pl_strike_i,
   output logic                 rsp_valid_o,
   output logic [ID_W-1:0]      rsp_id_o,
   output logic [7:0]           rsp_x_o,
   output logic [7:0]           rsp_y_o,
   output logic [3:0]           rsp_strike_o,
   output logic                 rsp_err_o
);

   logic [PH_W-1:0]              phase_q, phase_d;
   logic [ID_W-1:0]              ptr_q, ptr_d;
   logic [4:0]                   pl_width_q, pl_width_d;
   logic [4:0]                   pl_height_q, pl_height_d;
   logic                         pl_issue_q, pl_issue_d;
   logic [ID_W-1:0]              issue_id_q, issue_id_d;
   logic [RSP_LAT-1:0]           tag_vld_q, tag_vld_d;
   logic [RSP_LAT-1:0][ID_W-1:0] tag_id_q, tag_id_d;
   logic                         rsp_valid_q, rsp_valid_d;
   logic [ID_W-1:0]              rsp_id_q, rsp_id_d;
   logic [7:0]                   rsp_x_q, rsp_x_d;
   logic [7:0]                   rsp_y_q, rsp_y_d;
   logic [3:0]                   rsp_strike_q, rsp_strike_d;
`ifdef DIM_CHECK_EN
   logic                         rej_q, rej_d;
   logic [RSP_LAT-1:0]           tag_err_q, tag_err_d;
   logic                         rsp_err_q, rsp_err_d;
`endif

   logic                         grant_found;
   logic                         grant_valid;
   logic [ID_W-1:0]              grant_id;
   logic [ID_W:0]                cand;
   logic [4:0]                   grant_w;
   logic [4:0]                   grant_h;
   logic                         dim_ok;
   logic                         tag_in_vld;
   logic                         tag_out_err;

   // Round-robin search starting at the pointer, wrapping around the requesters
   always_comb begin
      grant_found = 1'b0;
      grant_id    = '0;
      cand        = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = {1'b0, ptr_q} + (ID_W+1)'(k);
         if (cand >= (ID_W+1)'(NUM_REQ)) begin
            cand = cand - (ID_W+1)'(NUM_REQ);
         end
         if (!grant_found && req_valid_i[cand[ID_W-1:0]]) begin
            grant_found = 1'b1;
            grant_id    = cand[ID_W-1:0];
         end
      end
   end

   // Grant qualification, dimension screening and the combinational one-hot ready
   always_comb begin
      grant_valid = grant_found && (phase_q == '0);
      grant_w     = req_width_i[int'(grant_id)*5 +: 5];
      grant_h     = req_height_i[int'(grant_id)*5 +: 5];
`ifdef DIM_CHECK_EN
      dim_ok      = (grant_w >= 5'd4) && (grant_w <= 5'd16) &&
                    (grant_h >= 5'd4) && (grant_h <= 5'd16);
`else
      dim_ok      = 1'b1;
`endif
      req_ready_o = '0;
      // Ready is suppressed while reset is held so every output reads 0 in reset
      if (grant_valid && rst_i) begin
         req_ready_o[grant_id] = 1'b1;
      end
   end

   // Next-state for phase, pointer, issue registers, tag pipe and response registers
   always_comb begin
      phase_d      = (phase_q == PH_W'(SLOT_CYC-1)) ? '0 : phase_q + 1'b1;
      ptr_d        = ptr_q;
      pl_width_d   = pl_width_q;
      pl_height_d  = pl_height_q;
      pl_issue_d   = 1'b0;
      issue_id_d   = issue_id_q;
`ifdef DIM_CHECK_EN
      rej_d        = 1'b0;
      tag_in_vld   = pl_issue_q | rej_q;
      tag_err_d    = {tag_err_q[RSP_LAT-2:0], rej_q};
      tag_out_err  = tag_err_q[RSP_LAT-1];
      rsp_err_d    = rsp_err_q;
`else
      tag_in_vld   = pl_issue_q;
      tag_out_err  = 1'b0;
`endif
      tag_vld_d    = {tag_vld_q[RSP_LAT-2:0], tag_in_vld};
      tag_id_d     = {tag_id_q[RSP_LAT-2:0], issue_id_q};
      rsp_valid_d  = tag_vld_q[RSP_LAT-1];
      rsp_id_d     = rsp_id_q;
      rsp_x_d      = rsp_x_q;
      rsp_y_d      = rsp_y_q;
      rsp_strike_d = rsp_strike_q;

      // Phase 0 decides what the issue registers carry for the whole slot
      if (phase_q == '0) begin
         issue_id_d  = grant_id;
         pl_issue_d  = grant_valid && dim_ok;
         pl_width_d  = (grant_valid && dim_ok) ? grant_w : 5'd0;
         pl_height_d = (grant_valid && dim_ok) ? grant_h : 5'd0;
`ifdef DIM_CHECK_EN
         rej_d       = grant_valid && !dim_ok;
`endif
         if (grant_valid) begin
            ptr_d = (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
         end
      end

      // A valid tag at the pipe output captures the pipeline result of this cycle
      if (tag_vld_q[RSP_LAT-1]) begin
         rsp_id_d     = tag_id_q[RSP_LAT-1];
         rsp_x_d      = tag_out_err ? 8'd0 : pl_x_i;
         rsp_y_d      = tag_out_err ? 8'd0 : pl_y_i;
         rsp_strike_d = tag_out_err ? 4'd0 : pl_strike_i;
`ifdef DIM_CHECK_EN
         rsp_err_d    = tag_out_err;
`endif
      end
   end

   // State registers; reset discards in-flight tags
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         phase_q      <= '0;
         ptr_q        <= '0;
         pl_width_q   <= '0;
         pl_height_q  <= '0;
         pl_issue_q   <= 1'b0;
         issue_id_q   <= '0;
         tag_vld_q    <= '0;
         tag_id_q     <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= '0;
         rsp_x_q      <= '0;
         rsp_y_q      <= '0;
         rsp_strike_q <= '0;
`ifdef DIM_CHECK_EN
         rej_q        <= 1'b0;
         tag_err_q    <= '0;
         rsp_err_q    <= 1'b0;
`endif
      end else begin
         phase_q      <= phase_d;
         ptr_q        <= ptr_d;
         pl_width_q   <= pl_width_d;
         pl_height_q  <= pl_height_d;
         pl_issue_q   <= pl_issue_d;
         issue_id_q   <= issue_id_d;
         tag_vld_q    <= tag_vld_d;
         tag_id_q     <= tag_id_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_x_q      <= rsp_x_d;
         rsp_y_q      <= rsp_y_d;
         rsp_strike_q <= rsp_strike_d;
`ifdef DIM_CHECK_EN
         rej_q        <= rej_d;
         tag_err_q    <= tag_err_d;
         rsp_err_q    <= rsp_err_d;
`endif
      end
   end

   assign slot_phase_o = phase_q;
   assign pl_width_o   = pl_width_q;
   assign pl_height_o  = pl_height_q;
   assign pl_issue_o   = pl_issue_q;
   assign rsp_valid_o  = rsp_valid_q;
   assign rsp_id_o     = rsp_id_q;
   assign rsp_x_o      = rsp_x_q;
   assign rsp_y_o      = rsp_y_q;
   assign rsp_strike_o = rsp_strike_q;
`ifdef DIM_CHECK_EN
   assign rsp_err_o    = rsp_err_q;
`else
   assign rsp_err_o    = 1'b0;
`endif

endmodule

// File: tb/tb_rect_issue_scheduler.sv
// tb/tb_rect_issue_scheduler.sv - self-checking bench for rect_issue_scheduler
module tb_rect_issue_scheduler;

   localparam int NUM_REQ  = 4;
   localparam int SLOT_CYC = 4;
   localparam int RSP_LAT  = 8;
   localparam int ID_W     = 2;

   logic                 clk_i = 1'b0;
   logic                 rst_i = 1'b0;
   logic [NUM_REQ-1:0]   req_valid_i = '0;
   logic [5*NUM_REQ-1:0] req_width_i = '0;
   logic [5*NUM_REQ-1:0] req_height_i = '0;
   logic [NUM_REQ-1:0]   req_ready_o;
   logic [4:0]           pl_width_o;
   logic [4:0]           pl_height_o;
   logic                 pl_issue_o;
   logic [1:0]           slot_phase_o;
   logic [7:0]           pl_x_i;
   logic [7:0]           pl_y_i;
   logic [3:0]           pl_strike_i;
   logic                 rsp_valid_o;
   logic [ID_W-1:0]      rsp_id_o;
   logic [7:0]           rsp_x_o;
   logic [7:0]           rsp_y_o;
   logic [3:0]           rsp_strike_o;
   logic                 rsp_err_o;

   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] tick = '0;

   rect_issue_scheduler #(
      .NUM_REQ(NUM_REQ), .SLOT_CYC(SLOT_CYC), .RSP_LAT(RSP_LAT), .ID_W(ID_W), .PH_W(2)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .req_valid_i(req_valid_i), .req_width_i(req_width_i), .req_height_i(req_height_i),
      .req_ready_o(req_ready_o),
      .pl_width_o(pl_width_o), .pl_height_o(pl_height_o), .pl_issue_o(pl_issue_o),
      .slot_phase_o(slot_phase_o),
      .pl_x_i(pl_x_i), .pl_y_i(pl_y_i), .pl_strike_i(pl_strike_i),
      .rsp_valid_o(rsp_valid_o), .rsp_id_o(rsp_id_o), .rsp_x_o(rsp_x_o),
      .rsp_y_o(rsp_y_o), .rsp_strike_o(rsp_strike_o), .rsp_err_o(rsp_err_o)
   );

   always #5 clk_i = ~clk_i;

   // Stand-in pipeline: results are a known function of the cycle number
   function automatic logic [7:0] fx(input logic [31:0] t);
      logic [31:0] v;
      v = t * 32'd7 + 32'd3;
      return v[7:0];
   endfunction
   function automatic logic [7:0] fy(input logic [31:0] t);
      return t[7:0] ^ 8'h5a;
   endfunction
   function automatic logic [3:0] fs(input logic [31:0] t);
      return t[3:0] ^ 4'h9;
   endfunction

   always @(posedge clk_i) tick <= tick + 32'd1;
   assign pl_x_i      = fx(tick);
   assign pl_y_i      = fy(tick);
   assign pl_strike_i = fs(tick);

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit dim_reject(input int w, input int h);
`ifdef DIM_CHECK_EN
      return !(w >= 4 && w <= 16 && h >= 4 && h <= 16);
`else
      return 1'b0;
`endif
   endfunction

   // ---------------- behavioural model + per-cycle compare ----------------
   typedef struct { int due; int id; bit err; } rsp_t;
   rsp_t rq[$];
   int   mcyc, mph, mptr, mw, mh;
   bit   miss;
   int   mrx, mry, mrs;

   always @(negedge clk_i) begin
      int  g;
      int  idx;
      int  w, h;
      logic [NUM_REQ-1:0] exp_ready;
      bit  ev;
      bit  eerr;
      int  eid;
      if (!rst_i) begin
         chk("reset_outputs",
             {req_ready_o, pl_width_o, pl_height_o, pl_issue_o, slot_phase_o, rsp_valid_o,
              rsp_id_o, rsp_x_o, rsp_y_o, rsp_strike_o, rsp_err_o}, 64'd0);
         mcyc = 0; mph = 0; mptr = 0; mw = 0; mh = 0; miss = 0;
         mrx = 0; mry = 0; mrs = 0;
         rq.delete();
      end else begin
         g = -1;
         for (int k = 0; k < NUM_REQ; k++) begin
            idx = (mptr + k) % NUM_REQ;
            if (g < 0 && req_valid_i[idx]) g = idx;
         end
         exp_ready = '0;
         if (mph == 0 && g >= 0) exp_ready[g] = 1'b1;
         chk("slot_phase", 64'(slot_phase_o), 64'(mph));
         chk("req_ready", 64'(req_ready_o), 64'(exp_ready));
         chk("pl_width", 64'(pl_width_o), 64'(mw));
         chk("pl_height", 64'(pl_height_o), 64'(mh));
         chk("pl_issue", 64'(pl_issue_o), 64'(miss));

         ev = 0; eerr = 0; eid = 0;
         if (rq.size() > 0 && rq[0].due == mcyc) begin
            ev = 1; eid = rq[0].id; eerr = rq[0].err;
            void'(rq.pop_front());
            mrx = eerr ? 0 : int'(fx(tick - 32'd1));
            mry = eerr ? 0 : int'(fy(tick - 32'd1));
            mrs = eerr ? 0 : int'(fs(tick - 32'd1));
         end
         chk("rsp_valid", 64'(rsp_valid_o), 64'(ev));
         if (ev) begin
            chk("rsp_id", 64'(rsp_id_o), 64'(eid));
            chk("rsp_err", 64'(rsp_err_o), 64'(eerr));
         end
         chk("rsp_x", 64'(rsp_x_o), 64'(mrx));
         chk("rsp_y", 64'(rsp_y_o), 64'(mry));
         chk("rsp_strike", 64'(rsp_strike_o), 64'(mrs));

         if (mph == 0) begin
            if (g >= 0) begin
               w = int'(req_width_i[g*5 +: 5]);
               h = int'(req_height_i[g*5 +: 5]);
               eerr = dim_reject(w, h);
               mw   = eerr ? 0 : w;
               mh   = eerr ? 0 : h;
               miss = !eerr;
               mptr = (g + 1) % NUM_REQ;
               rq.push_back('{due: mcyc + RSP_LAT + 2, id: g, err: eerr});
            end else begin
               mw = 0; mh = 0; miss = 0;
            end
         end else if (mph == 1) begin
            miss = 0;
         end
         mph  = (mph + 1) % SLOT_CYC;
         mcyc = mcyc + 1;
      end
   end

   // ---------------- directed stimulus with literal expectations ----------------
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   task automatic set_req(input int k, input int w, input int h);
      req_width_i[k*5 +: 5]  = 5'(w);
      req_height_i[k*5 +: 5] = 5'(h);
   endtask

   int rr_seq [5] = '{0, 1, 2, 3, 0};
   int d6_w   [3] = '{3, 4, 16};
   int d6_h   [3] = '{10, 16, 17};

   initial begin
      logic [3:0] one_hot;
      bit rej;
      // 1. reset and idle
      rst_i = 1'b0;
      step(3);
      rst_i = 1'b1;
      chk("t1_phase_after_reset", 64'(slot_phase_o), 64'd0);
      chk("t1_issue_after_reset", 64'(pl_issue_o), 64'd0);
      step(40);
      chk("t1_idle_no_rsp", 64'(rsp_valid_o), 64'd0);

      // 2. single request from requester 2
      set_req(2, 8, 5);
      req_valid_i = 4'b0100;
      #1;
      chk("t2_ready", 64'(req_ready_o), 64'b0100);
      step(1);
      req_valid_i = '0;
      chk("t2_width", 64'(pl_width_o), 64'd8);
      chk("t2_height", 64'(pl_height_o), 64'd5);
      chk("t2_issue", 64'(pl_issue_o), 64'd1);
      step(RSP_LAT);
      chk("t2_rsp_not_early", 64'(rsp_valid_o), 64'd0);
      step(1);
      chk("t2_rsp_valid", 64'(rsp_valid_o), 64'd1);
      chk("t2_rsp_id", 64'(rsp_id_o), 64'd2);
      chk("t2_rsp_x", 64'(rsp_x_o), 64'(fx(tick - 32'd1)));

      // 3. round robin with all requesters active, from a fresh pointer
      rst_i = 1'b0;
      step(2);
      rst_i = 1'b1;
      for (int k = 0; k < NUM_REQ; k++) set_req(k, 4 + k, 10 + k);
      req_valid_i = 4'b1111;
      for (int s = 0; s < 5; s++) begin
         #1;
         one_hot = 4'b0001 << rr_seq[s];
         chk("t3_rr_grant", 64'(req_ready_o), 64'(one_hot));
         step(1);
         if (s == 4) req_valid_i = '0;
         step(3);
      end
      step(12);

      // 4. requester 1 active every other slot
      set_req(1, 6, 7);
      for (int s = 0; s < 6; s++) begin
         if (s % 2 == 0) begin
            req_valid_i = 4'b0010;
            #1;
            chk("t4_ready", 64'(req_ready_o), 64'b0010);
            step(1);
            req_valid_i = '0;
            chk("t4_issue", 64'(pl_issue_o), 64'd1);
            chk("t4_width", 64'(pl_width_o), 64'd6);
         end else begin
            #1;
            chk("t4_bubble_ready", 64'(req_ready_o), 64'd0);
            step(1);
            chk("t4_bubble_issue", 64'(pl_issue_o), 64'd0);
            chk("t4_bubble_width", 64'(pl_width_o), 64'd0);
         end
         step(3);
      end
      step(12);

      // 5. reset while a rectangle is in flight
      set_req(3, 9, 9);
      req_valid_i = 4'b1000;
      step(1);
      req_valid_i = '0;
      step(3);
      rst_i = 1'b0;
      step(2);
      rst_i = 1'b1;
      set_req(1, 5, 6);
      req_valid_i = 4'b1010;
      #1;
      chk("t5_post_reset_grant", 64'(req_ready_o), 64'b0010);
      step(1);
      req_valid_i = 4'b1000;
      step(3);
      #1;
      chk("t5_second_grant", 64'(req_ready_o), 64'b1000);
      step(1);
      req_valid_i = '0;
      step(15);

      // 6. dimension screening on requester 0 (out-of-range and boundary sizes)
      for (int s = 0; s < 3; s++) begin
         rej = dim_reject(d6_w[s], d6_h[s]);
         set_req(0, d6_w[s], d6_h[s]);
         req_valid_i = 4'b0001;
         #1;
         chk("t6_ready", 64'(req_ready_o), 64'b0001);
         step(1);
         req_valid_i = '0;
         chk("t6_issue", 64'(pl_issue_o), 64'(!rej));
         chk("t6_width", 64'(pl_width_o), rej ? 64'd0 : 64'(d6_w[s]));
         step(RSP_LAT + 1);
         chk("t6_rsp_valid", 64'(rsp_valid_o), 64'd1);
         chk("t6_rsp_err", 64'(rsp_err_o), 64'(rej));
         chk("t6_rsp_x", 64'(rsp_x_o), rej ? 64'd0 : 64'(fx(tick - 32'd1)));
         chk("t6_rsp_y", 64'(rsp_y_o), rej ? 64'd0 : 64'(fy(tick - 32'd1)));
         step(2);
      end
      step(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
